// File: rtl/mm_iddmm_driver.sv
// Operand/result adapter for the Montgomery multiplier: serialises an x/y
// operand pair into K-bit words and gathers N result words into one response.
module mm_iddmm_driver #(
    parameter int unsigned K       = 128,
    parameter int unsigned N       = 16,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned TO_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [K*N-1:0]   req_x_i,
    input  logic [K*N-1:0]   req_y_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [K*N-1:0]   rsp_result_o,
    output logic             rsp_timeout_o,
    output logic             mm_start_o,
    output logic [K-1:0]     mm_x_o,
    output logic             mm_x_valid_o,
    output logic [K-1:0]     mm_y_o,
    output logic             mm_y_valid_o,
    input  logic [K-1:0]     mm_result_i,
    input  logic             mm_valid_i
);

    localparam int unsigned W  = K * N;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);
    // Timeout fires at the end of the TIMEOUT-th WAIT_RES cycle, so the
    // response appears exactly TIMEOUT cycles after WAIT_RES entry.
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Y,
        S_START,
        S_SEND_X,
        S_WAIT_RES,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nxt;
    logic [TO_W-1:0] to_q, to_d;
    logic [W-1:0]    x_q, x_d, y_q, y_d;
    logic [K-1:0]    mm_x_q, mm_x_d, mm_y_q, mm_y_d;
    logic            mm_x_valid_q, mm_x_valid_d;
    logic            mm_y_valid_q, mm_y_valid_d;
    logic            mm_start_q, mm_start_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [W-1:0]    rsp_result_q, rsp_result_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        to_d          = to_q;
        x_d           = x_q;
        y_d           = y_q;
        mm_x_d        = mm_x_q;
        mm_y_d        = mm_y_q;
        mm_x_valid_d  = 1'b0;
        mm_y_valid_d  = 1'b0;
        mm_start_d    = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_result_d  = rsp_result_q;
        idx_nxt       = idx_q + IW'(1);

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    x_d           = req_x_i;
                    y_d           = req_y_i;
                    rsp_result_d  = '0;
                    rsp_timeout_d = 1'b0;
                    idx_d         = '0;
                    mm_y_d        = req_y_i[K-1:0];
                    mm_y_valid_d  = 1'b1;
                    state_d       = S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                // idx_q is the y word currently on the bus
                if (idx_q == LAST_IDX) begin
                    mm_start_d = 1'b1;
                    state_d    = S_START;
                end else begin
                    idx_d        = idx_nxt;
                    mm_y_d       = y_q[32'(idx_nxt) * K +: K];
                    mm_y_valid_d = 1'b1;
                end
            end
            S_START: begin
                idx_d        = '0;
                mm_x_d       = x_q[K-1:0];
                mm_x_valid_d = 1'b1;
                state_d      = S_SEND_X;
            end
            S_SEND_X: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    to_d    = '0;
                    state_d = S_WAIT_RES;
                end else begin
                    idx_d        = idx_nxt;
                    mm_x_d       = x_q[32'(idx_nxt) * K +: K];
                    mm_x_valid_d = 1'b1;
                end
            end
            S_WAIT_RES: begin
                // idx_q now counts received result words
                to_d = to_q + TO_W'(1);
                if (mm_valid_i) begin
                    rsp_result_d[32'(idx_q) * K +: K] = mm_result_i;
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_nxt;
                    end
                end
                if (mm_valid_i && (idx_q == LAST_IDX)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (to_q == TO_LAST) begin
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            to_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            mm_x_q        <= '0;
            mm_y_q        <= '0;
            mm_x_valid_q  <= 1'b0;
            mm_y_valid_q  <= 1'b0;
            mm_start_q    <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_result_q  <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            to_q          <= to_d;
            x_q           <= x_d;
            y_q           <= y_d;
            mm_x_q        <= mm_x_d;
            mm_y_q        <= mm_y_d;
            mm_x_valid_q  <= mm_x_valid_d;
            mm_y_valid_q  <= mm_y_valid_d;
            mm_start_q    <= mm_start_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_result_q  <= rsp_result_d;
        end
    end

    assign req_ready_o   = (state_q == S_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_result_o  = rsp_result_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign mm_start_o    = mm_start_q;
    assign mm_x_o        = mm_x_q;
    assign mm_x_valid_o  = mm_x_valid_q;
    assign mm_y_o        = mm_y_q;
    assign mm_y_valid_o  = mm_y_valid_q;

endmodule

// File: tb/tb_mm_iddmm_driver.sv
// Self-checking bench for mm_iddmm_driver: table-driven transactions, a
// mid-operation reset sequence and randomized transactions against a
// cycle-level reference model of the operand/response protocol.
module tb_mm_iddmm_driver;

    localparam int unsigned K       = 32;
    localparam int unsigned N       = 16;
    localparam int unsigned TIMEOUT = 100;
    localparam int unsigned TO_W    = 16;
    localparam int unsigned W       = K * N;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [W-1:0]   req_x = '0;
    logic [W-1:0]   req_y = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_result;
    logic           rsp_timeout;
    logic           mm_start;
    logic [K-1:0]   mm_x;
    logic           mm_x_valid;
    logic [K-1:0]   mm_y;
    logic           mm_y_valid;
    logic [K-1:0]   mm_result = '0;
    logic           mm_valid = 1'b0;

    mm_iddmm_driver #(.K(K), .N(N), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_x_i      (req_x),
        .req_y_i      (req_y),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_timeout_o(rsp_timeout),
        .mm_start_o   (mm_start),
        .mm_x_o       (mm_x),
        .mm_x_valid_o (mm_x_valid),
        .mm_y_o       (mm_y),
        .mm_y_valid_o (mm_y_valid),
        .mm_result_i  (mm_result),
        .mm_valid_i   (mm_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {req_ready, mm_y_valid, mm_start, mm_x_valid, rsp_valid};
    endfunction

    function automatic logic [W-1:0] build(input logic [K-1:0] w0, input bit fill);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            if (i == 0 || fill) v[i*K +: K] = w0 + K'(i);
        return v;
    endfunction

    // Current transaction description shared with run_txn.
    logic [W-1:0] cur_x, cur_y, nxt_x, nxt_y;
    int           off[N];
    logic [K-1:0] bval[N];
    int           nb, hold;
    bit           dead, nxt_valid;

    // One full transaction; beat offsets are relative to WAIT_RES entry.
    task automatic run_txn(output int lat, output bit to_seen);
        int a, e, r, h, rel;
        bit exp_to, yv, st, xv, rv, seen;
        logic [W-1:0] exp_res;
        logic [W-1:0] tmp;

        exp_res = '0;
        rel     = TIMEOUT;
        exp_to  = 1'b1;
        for (int j = 0; j < nb; j++)
            if (off[j] <= int'(TIMEOUT) - 1) exp_res[j*K +: K] = bval[j];
        if (nb == N && off[N-1] <= int'(TIMEOUT) - 1) begin
            rel    = off[N-1] + 1;
            exp_to = 1'b0;
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        mm_valid  = 1'b0;
        a = cyc;
        chk("idle_flags", W'(flags()), W'(5'b10000));
        req_valid = 1'b1;
        req_x     = cur_x;
        req_y     = cur_y;
        e = a + 2 * N + 2;
        r = e + rel;
        h = r + hold;
        lat = -1;
        to_seen = 1'b0;
        seen = 1'b0;

        for (int c = a + 1; c <= h; c++) begin
            @(negedge clk);
            yv = (c >= a + 1) && (c <= a + N);
            st = (c == a + N + 1);
            xv = (c >= a + N + 2) && (c <= a + 2 * N + 1);
            rv = (c >= r);
            chk("flags", W'(flags()), W'({1'b0, yv, st, xv, rv}));
            if (yv) begin
                tmp = cur_y;
                chk("mm_y", W'(mm_y), W'(tmp[(c-a-1)*K +: K]));
            end
            if (xv) begin
                tmp = cur_x;
                chk("mm_x", W'(mm_x), W'(tmp[(c-a-N-2)*K +: K]));
            end
            if (rv) begin
                chk("rsp_result", rsp_result, exp_res);
                chk("rsp_timeout", W'(rsp_timeout), W'(exp_to));
            end
            if (rsp_valid && !seen) begin
                seen = 1'b1;
                lat = c - e;
                to_seen = rsp_timeout;
            end
            // Inputs for this cycle
            req_valid = nxt_valid;
            req_x     = nxt_x;
            req_y     = nxt_y;
            mm_valid  = 1'b0;
            mm_result = '0;
            if (dead && (c == a + 3 || c == a + N + 5)) begin
                mm_valid  = 1'b1;
                mm_result = K'(32'hDEAD);
            end
            for (int j = 0; j < nb; j++)
                if (e + off[j] == c) begin
                    mm_valid  = 1'b1;
                    mm_result = bval[j];
                end
            rsp_ready = (c == h);
        end
    endtask

    typedef struct {
        logic [K-1:0] x0;
        logic [K-1:0] y0;
        bit fill;
        int f, g, nbt, hold;
        bit dead, nxt, exp_to;
        int exp_lat;
    } vec_t;

    function automatic vec_t mk(input logic [K-1:0] x0, input logic [K-1:0] y0, input bit fill,
                                input int f, input int g, input int nbt, input int hd,
                                input bit dd, input bit nx, input bit et, input int el);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.fill = fill; v.f = f; v.g = g; v.nbt = nbt;
        v.hold = hd; v.dead = dd; v.nxt = nx; v.exp_to = et; v.exp_lat = el;
        return v;
    endfunction

    vec_t tbl[8];

    initial begin
        int lat;
        bit tos;
        int o;

        tbl[0] = mk(32'd3,         32'd5,         1'b0, 0,  0, 16, 0,  1'b0, 1'b0, 1'b0, 16);
        tbl[1] = mk(32'h1000_0001, 32'h2000_0002, 1'b1, 3,  2, 16, 1,  1'b0, 1'b0, 1'b0, 49);
        tbl[2] = mk(32'd7,         32'd9,         1'b1, 0,  0, 5,  2,  1'b0, 1'b0, 1'b1, 100);
        tbl[3] = mk(32'hA0,        32'hB0,        1'b1, 9,  6, 16, 0,  1'b0, 1'b0, 1'b1, 100);
        tbl[4] = mk(32'hA1,        32'hB1,        1'b1, 84, 0, 16, 0,  1'b0, 1'b0, 1'b0, 100);
        tbl[5] = mk(32'hA2,        32'hB2,        1'b1, 85, 0, 16, 0,  1'b0, 1'b0, 1'b1, 100);
        tbl[6] = mk(32'hE0,        32'hF0,        1'b1, 0,  1, 16, 20, 1'b1, 1'b1, 1'b0, 31);
        tbl[7] = mk(32'hE1,        32'hF1,        1'b1, 2,  0, 16, 0,  1'b0, 1'b0, 1'b0, 18);

        nxt_valid = 1'b0;
        nxt_x = '0;
        nxt_y = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_flags", W'({flags(), rsp_timeout}), W'(6'b100000));
        chk("reset_mm_x", W'(mm_x), '0);
        chk("reset_mm_y", W'(mm_y), '0);
        chk("reset_result", rsp_result, '0);

        for (int i = 0; i < 8; i++) begin
            cur_x = build(tbl[i].x0, tbl[i].fill);
            cur_y = build(tbl[i].y0, tbl[i].fill);
            nb = tbl[i].nbt;
            for (int j = 0; j < nb; j++) begin
                off[j]  = tbl[i].f + j * (tbl[i].g + 1);
                bval[j] = K'(32'h11 + j);
            end
            hold = tbl[i].hold;
            dead = tbl[i].dead;
            nxt_valid = tbl[i].nxt && (i < 7);
            nxt_x = '0;
            nxt_y = '0;
            if (nxt_valid) begin
                nxt_x = build(tbl[i+1].x0, tbl[i+1].fill);
                nxt_y = build(tbl[i+1].y0, tbl[i+1].fill);
            end
            run_txn(lat, tos);
            chk("tbl_latency", W'(lat), W'(tbl[i].exp_lat));
            chk("tbl_timeout", W'(tos), W'(tbl[i].exp_to));
        end
        nxt_valid = 1'b0;

        // Reset asserted while x word 7 is on the bus
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        mm_valid  = 1'b0;
        o = cyc;
        cur_x = build(32'hC0, 1'b1);
        cur_y = build(32'hD0, 1'b1);
        req_valid = 1'b1;
        req_x = cur_x;
        req_y = cur_y;
        @(negedge clk);
        req_valid = 1'b0;
        while (cyc < o + int'(N) + 9) @(negedge clk);
        chk("pre_reset_flags", W'(flags()), W'(5'b00010));
        chk("pre_reset_x7", W'(mm_x), W'(K'(32'hC7)));
        #2 rst_n = 1'b0;
        #1;
        chk("in_reset_flags", W'({flags(), rsp_timeout}), W'(6'b100000));
        chk("in_reset_data", W'({mm_x, mm_y}), '0);
        chk("in_reset_result", rsp_result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_x = build(32'h50, 1'b1);
        cur_y = build(32'h60, 1'b1);
        nb = N;
        for (int j = 0; j < N; j++) begin
            off[j]  = 1 + j;
            bval[j] = K'(32'h300 + j);
        end
        hold = 0;
        dead = 1'b0;
        run_txn(lat, tos);
        chk("post_reset_latency", W'(lat), W'(17));

        // Randomized transactions
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) begin
                cur_x[i*K +: K] = $urandom;
                cur_y[i*K +: K] = $urandom;
            end
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N - 1) : N;
            o = $urandom_range(0, 5);
            for (int j = 0; j < nb; j++) begin
                off[j]  = o;
                bval[j] = $urandom;
                o = o + 1 + $urandom_range(0, 4);
            end
            hold = $urandom_range(0, 3);
            dead = 1'(t % 2);
            run_txn(lat, tos);
        end

        @(negedge clk);
        rsp_ready = 1'b0;
        mm_valid  = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mm_iddmm_driver.md
Name: mm_iddmm_driver

Overview:
- Front/back-end adapter for the Montgomery modular-multiply top (mm_start / mm_x / mm_y / mm_result port set).
- Upstream side: accepts one full-width operand pair (x, y, each K*N bits) over a valid/ready handshake.
- Toward the multiplier: streams y then x as K-bit words, low word first, with the start pulse placed between them.
- Downstream side: collects the N result words into one K*N-bit response, with a timeout guard.

Parameters:
K, 128, bits per word
N, 16, words per operand
TIMEOUT, 65535, max cycles in WAIT_RES before aborting
TO_W, 16, timeout counter width, must hold TIMEOUT

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  operand pair valid
req_ready  output  1  driver can accept a request
req_x  input  K*N  operand x, word i = bits [i*K +: K]
req_y  input  K*N  operand y, same packing
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_result  output  K*N  collected result, word i from the i-th mm_valid beat
rsp_timeout  output  1  response is an aborted/partial result
mm_start  output  1  one-cycle start pulse to the multiplier
mm_x  output  K  x word
mm_x_valid  output  1  x word strobe
mm_y  output  K  y word
mm_y_valid  output  1  y word strobe
mm_result  input  K  result word from the multiplier
mm_valid  input  1  result word strobe

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low.
- Registered outputs: all outputs are registered except req_ready.
- Reset values:
  - rsp_valid, rsp_timeout, mm_start, mm_x_valid, mm_y_valid = 0.
  - mm_x, mm_y, rsp_result = 0.
  - FSM in IDLE, so req_ready = 1.
- FSM states: IDLE, LOAD_Y, START, SEND_X, WAIT_RES, RESP.
- IDLE:
  - req_ready = (state == IDLE).
  - A request is accepted on req_valid && req_ready: latch req_x and req_y, clear rsp_result to 0, clear word index i, go to LOAD_Y.
- LOAD_Y:
  - Runs exactly N consecutive cycles with mm_y_valid = 1 and mm_y = y word i, i = 0..N-1.
  - After word N-1, go to START.
- START:
  - Exactly one cycle with mm_start = 1. All strobes are 0 in this cycle.
- SEND_X:
  - Begins the cycle immediately after mm_start.
  - N consecutive cycles with mm_x_valid = 1 and mm_x = x word i, i = 0..N-1, no gaps.
  - After word N-1, go to WAIT_RES.
- Cycle timing (request accepted at cycle 0): y words on cycles 1..N, mm_start on N+1, x words on N+2..2N+1.
- WAIT_RES:
  - Timeout counter starts at 0 on entry and increments every cycle.
  - On each mm_valid: rsp_result word r <= mm_result, r++.
  - When mm_valid arrives with r == N-1: go to RESP with rsp_timeout = 0.
  - If the counter reaches TIMEOUT before that: go to RESP with rsp_timeout = 1. Unfilled words stay 0.
  - If the timeout and the final mm_valid land in the same cycle, the final word wins: store it and set rsp_timeout = 0.
- RESP:
  - rsp_valid = 1. rsp_result and rsp_timeout are held stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0, go to IDLE.
  - A new request can be accepted in the cycle after that.
- mm_valid outside WAIT_RES is ignored; rsp_result is not modified. Beats beyond N are impossible by construction.
- mm_x, mm_y retain their last value when their strobes are 0. They are don't-care for the multiplier.
- Index counters are ceil(log2 N) bits and never wrap past N-1.
- Reset asserted mid-operation: immediate return to IDLE, all outputs at reset values, latched operands discarded.
- Throughput: one operation in flight. req_ready = 0 from acceptance until the RESP handshake completes.

Test Plan:
1. Reset, then req_x = 3, req_y = 5, responder returns words 0x11..0x1N → y strobes on cycles 1..16 with mm_y = 5, 0, 0, …; mm_start at cycle 17; mm_x = 3, 0, … on cycles 18..33; rsp_result words = 0x11..0x1N, rsp_timeout = 0.
2. Responder inserts random gaps between mm_valid beats → word order is preserved; rsp_valid rises the cycle after the 16th beat.
3. Responder sends only 5 beats, TIMEOUT = 100 → rsp_valid rises exactly 100 cycles after WAIT_RES entry; rsp_timeout = 1; words 5..15 = 0.
4. Hold rsp_ready = 0 for 20 cycles with req_valid = 1 → rsp_valid and rsp_result are stable, req_ready = 0; after rsp_ready the second request is accepted one cycle later.
5. Assert rst_n = 0 during SEND_X (word 7) → all strobes drop immediately, req_ready = 1 after release, the next request runs cleanly.
6. mm_valid pulsed during LOAD_Y and SEND_X with value 0xDEAD → ignored; final rsp_result contains no 0xDEAD word.
